// File: rtl/key_event_pkg.sv
// Shared types and elaboration-time helpers for the key event controller.
package key_event_pkg;

  localparam int KEY_ID_MAX_W = 4;

  typedef struct packed {
    logic [KEY_ID_MAX_W-1:0] id;
    logic                    evt_type;
  } key_evt_t;

  function automatic int key_id_w(input int num_keys);
    if (num_keys <= 1) begin
      return 1;
    end else begin
      return $clog2(num_keys);
    end
  endfunction

  // Number of stable synchronized cycles required, never below one.
  function automatic int db_cycles(input int glitch_ns, input int clk_mhz);
    int prod;
    prod = glitch_ns * clk_mhz;
    if (prod <= 1000) begin
      return 1;
    end else begin
      return (prod + 999) / 1000;
    end
  endfunction

endpackage

// File: rtl/key_db_lane.sv
// One key lane: 2-flop synchronizer, stability counter, debounced level and edge strobe.
module key_db_lane #(
  parameter int DB_CYCLES = 5
) (
  input  logic clk_i,
  input  logic srst_n_i,
  input  logic key_i,
  output logic level_o,
  output logic edge_o
);

  localparam int CNT_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic             sync1_r;
  logic             sync2_r;
  logic [CNT_W-1:0] cnt_r;

  // Synchronize, then accept a new level only after DB_CYCLES consecutive differing samples.
  always_ff @(posedge clk_i) begin
    if (!srst_n_i) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
      cnt_r   <= '0;
      level_o <= 1'b0;
      edge_o  <= 1'b0;
    end else begin
      sync1_r <= key_i;
      sync2_r <= sync1_r;
      edge_o  <= 1'b0;
      if (sync2_r == level_o) begin
        cnt_r <= '0;
      end else if (cnt_r == CNT_LAST) begin
        level_o <= sync2_r;
        cnt_r   <= '0;
        edge_o  <= 1'b1;
      end else begin
        cnt_r <= cnt_r + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/key_event_ctrl.sv
// Debounced key inputs feeding a round-robin arbitrated event FIFO.
// Build option: define KEY_RELEASE_EVT_EN to also queue release events.
module key_event_ctrl
  import key_event_pkg::*;
#(
  parameter int NUM_KEYS       = 4,
  parameter int CLK_FREQ_MHZ   = 5,
  parameter int GLITCH_TIME_NS = 1000,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                          clk_i,
  input  logic                          srst_n_i,
  input  logic [NUM_KEYS-1:0]           key_i,
  output logic [NUM_KEYS-1:0]           key_level_o,
  output logic                          evt_valid_o,
  output logic [key_id_w(NUM_KEYS)-1:0] evt_id_o,
  output logic                          evt_type_o,
  input  logic                          evt_ready_i,
  input  logic                          clr_ovf_i,
  output logic                          overflow_o
);

  localparam int KEY_ID_W  = key_id_w(NUM_KEYS);
  localparam int DB_CYCLES = db_cycles(GLITCH_TIME_NS, CLK_FREQ_MHZ);
  localparam int PTR_W     = $clog2(FIFO_DEPTH);
  localparam int CNT_W     = PTR_W + 1;
  localparam logic [CNT_W-1:0] FIFO_FULL = CNT_W'(FIFO_DEPTH);

  logic [NUM_KEYS-1:0] level_s;
  logic [NUM_KEYS-1:0] edge_s;
  logic [NUM_KEYS-1:0] evt_s;
  logic [NUM_KEYS-1:0] grant_s;
  logic [NUM_KEYS-1:0] pend_r;
  logic [NUM_KEYS-1:0] ptype_r;
  logic [KEY_ID_W-1:0] rr_start_r;
  logic [KEY_ID_W-1:0] cand_s;
  logic [KEY_ID_W-1:0] grant_idx_s;
  logic                grant_vld_s;
  logic                loss_s;
  logic                push_s;
  logic                pop_s;
  key_evt_t            mem_r [FIFO_DEPTH];
  key_evt_t            push_data_s;
  key_evt_t            head_nxt_s;
  logic [PTR_W-1:0]    wr_ptr_r;
  logic [PTR_W-1:0]    rd_ptr_r;
  logic [PTR_W-1:0]    rd_ptr_nxt_s;
  logic [CNT_W-1:0]    count_r;
  logic [CNT_W-1:0]    count_nxt_s;

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_lane
    key_db_lane #(
      .DB_CYCLES(DB_CYCLES)
    ) u_lane (
      .clk_i   (clk_i),
      .srst_n_i(srst_n_i),
      .key_i   (key_i[i]),
      .level_o (level_s[i]),
      .edge_o  (edge_s[i])
    );
  end

  assign key_level_o = level_s;

`ifdef KEY_RELEASE_EVT_EN
  assign evt_s = edge_s;
`else
  assign evt_s = edge_s & level_s;
`endif

  // Round-robin pick of one pending lane, only while the registered count leaves room.
  always_comb begin
    grant_vld_s = 1'b0;
    grant_idx_s = '0;
    cand_s      = '0;
    grant_s     = '0;
    if (count_r < FIFO_FULL) begin
      for (int k = 0; k < NUM_KEYS; k++) begin
        cand_s = KEY_ID_W'((int'(rr_start_r) + k) % NUM_KEYS);
        if (!grant_vld_s && pend_r[cand_s]) begin
          grant_vld_s = 1'b1;
          grant_idx_s = cand_s;
        end else begin
          grant_vld_s = grant_vld_s;
        end
      end
    end else begin
      grant_vld_s = 1'b0;
    end
    grant_s[grant_idx_s] = grant_vld_s;
  end

  // An event on a lane still holding an ungranted one is lost.
  assign loss_s = |(evt_s & pend_r & ~grant_s);

  // Pending flags, round-robin pointer and sticky overflow.
  always_ff @(posedge clk_i) begin
    if (!srst_n_i) begin
      pend_r     <= '0;
      ptype_r    <= '0;
      rr_start_r <= '0;
      overflow_o <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_KEYS; i++) begin
        if (evt_s[i] && (!pend_r[i] || grant_s[i])) begin
          pend_r[i]  <= 1'b1;
          ptype_r[i] <= ~level_s[i];
        end else if (grant_s[i]) begin
          pend_r[i] <= 1'b0;
        end else begin
          pend_r[i] <= pend_r[i];
        end
      end
      if (grant_vld_s) begin
        rr_start_r <= (grant_idx_s == KEY_ID_W'(NUM_KEYS - 1)) ? '0 : grant_idx_s + KEY_ID_W'(1);
      end else begin
        rr_start_r <= rr_start_r;
      end
      if (loss_s) begin
        overflow_o <= 1'b1;
      end else if (clr_ovf_i) begin
        overflow_o <= 1'b0;
      end else begin
        overflow_o <= overflow_o;
      end
    end
  end

  assign push_s      = grant_vld_s;
  assign pop_s       = evt_valid_o & evt_ready_i;
  assign push_data_s = {KEY_ID_MAX_W'(grant_idx_s), ptype_r[grant_idx_s]};

  // Next head of queue, so the output fields can be registered.
  always_comb begin
    rd_ptr_nxt_s = rd_ptr_r + PTR_W'(pop_s);
    count_nxt_s  = count_r + CNT_W'(push_s) - CNT_W'(pop_s);
    head_nxt_s   = '0;
    if (count_nxt_s == '0) begin
      head_nxt_s = '0;
    end else if (push_s && (wr_ptr_r == rd_ptr_nxt_s)) begin
      head_nxt_s = push_data_s;
    end else begin
      head_nxt_s = mem_r[rd_ptr_nxt_s];
    end
  end

  // Event FIFO storage, pointers and registered head outputs.
  always_ff @(posedge clk_i) begin
    if (!srst_n_i) begin
      for (int d = 0; d < FIFO_DEPTH; d++) begin
        mem_r[d] <= '0;
      end
      wr_ptr_r    <= '0;
      rd_ptr_r    <= '0;
      count_r     <= '0;
      evt_valid_o <= 1'b0;
      evt_id_o    <= '0;
      evt_type_o  <= 1'b0;
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= push_data_s;
        wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      rd_ptr_r    <= rd_ptr_nxt_s;
      count_r     <= count_nxt_s;
      evt_valid_o <= (count_nxt_s != '0);
      evt_id_o    <= KEY_ID_W'(head_nxt_s.id);
      evt_type_o  <= head_nxt_s.evt_type;
    end
  end

endmodule
